// File: rtl/timer_counter.sv
// Bus-mapped countdown timer with one-shot/auto-reload modes and a level IRQ.
// Optional macro TC_COUNT_WR_EN makes the COUNT register CPU-writable.
module timer_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

`ifdef TC_COUNT_WR_EN
  localparam bit COUNT_WR = 1'b1;
`else
  localparam bit COUNT_WR = 1'b0;
`endif

  state_t               state;
  logic                 ctrl_en;
  logic [1:0]           ctrl_mode;
  logic                 ctrl_im;
  logic [CNT_WIDTH-1:0] preset;
  logic [CNT_WIDTH-1:0] count;
  logic                 flag;

  logic wr_ctrl;
  logic wr_preset;
  logic wr_count;
  logic auto_reload;
  logic unused_addr;

  assign wr_ctrl     = WE && (Addr[3:2] == 2'd0);
  assign wr_preset   = WE && (Addr[3:2] == 2'd1);
  assign wr_count    = WE && (Addr[3:2] == 2'd2);
  // Only MODE=01 reloads; the undefined 1x encodings behave as one-shot.
  assign auto_reload = (ctrl_mode == 2'b01);
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  assign IRQ = ctrl_im & flag;

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      2'd0:    Dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      2'd1:    Dout = 32'(preset);
      2'd2:    Dout = 32'(count);
      default: Dout = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      flag      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrl_en) state <= S_LOAD;
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl_en) begin
            state <= S_IDLE;
          end else if (count <= ONE) begin
            count <= '0;
            flag  <= 1'b1;
            state <= S_INT;
          end else begin
            count <= count - ONE;
          end
        end
        S_INT: begin
          if (auto_reload) flag <= 1'b0;
          else             ctrl_en <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // CPU writes come last so they win over the FSM updates on the same edge.
      if (wr_ctrl) begin
        ctrl_en   <= Din[0];
        ctrl_mode <= Din[2:1];
        ctrl_im   <= Din[3];
        flag      <= 1'b0;
      end
      if (wr_preset) begin
        preset <= Din[CNT_WIDTH-1:0];
        flag   <= 1'b0;
      end
      if (COUNT_WR && wr_count) count <= Din[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register map, FSM timing, IRQ modes, reset abort.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_chk = 0;
  int n_err = 0;

  timer_counter #(.CNT_WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    Addr = {28'd0, r, 2'b00};
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] r, input logic [31:0] exp);
    Addr = {28'd0, r, 2'b00};
    #1;
    check(tag, Dout, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'd0, IRQ}, {31'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    #12;
    check_reg("rst_ctrl", 2'd0, 32'h0);
    check_reg("rst_preset", 2'd1, 32'h0);
    check_reg("rst_count", 2'd2, 32'h0);
    check_irq("rst_irq", 1'b0);
    #20;
    reset = 1'b1;
    tick(1);

    // One-shot: PRESET=3, CTRL=0x9 -> COUNT 3,2,1,0 at edges 2..5
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick(1);
    check_reg("os_load_count", 2'd2, 32'd0);
    tick(1);
    check_reg("os_count_e2", 2'd2, 32'd3);
    tick(1);
    check_reg("os_count_e3", 2'd2, 32'd2);
    tick(1);
    check_reg("os_count_e4", 2'd2, 32'd1);
    check_irq("os_irq_e4", 1'b0);
    tick(1);
    check_reg("os_count_e5", 2'd2, 32'd0);
    check_irq("os_irq_e5", 1'b1);
    tick(1);
    check_irq("os_irq_e6", 1'b1);
    check_reg("os_ctrl_e6", 2'd0, 32'h8);
    tick(3);
    check_irq("os_irq_held", 1'b1);

    // PRESET write clears flag; IM=0 run never raises IRQ
    wr(2'd1, 32'd5);
    check_irq("pre_wr_clr", 1'b0);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check_irq("im0_irq", 1'b0);
    end
    check_reg("im0_ctrl_done", 2'd0, 32'h0);
    check_reg("im0_count_done", 2'd2, 32'd0);

    // Auto-reload: PRESET=2, CTRL=0xB -> one-cycle pulse every 5 cycles
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      check_irq("ar_pulse", (k % 5) == 4);
    end
    check_reg("ar_ctrl", 2'd0, 32'hB);
    wr(2'd0, 32'h0);
    tick(4);

    // Pause at COUNT=6, resume reloads PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    tick(5);
    wr(2'd0, 32'h8);
    check_reg("pause_count", 2'd2, 32'd6);
    tick(3);
    check_reg("pause_hold", 2'd2, 32'd6);
    check_irq("pause_irq", 1'b0);
    wr(2'd0, 32'h9);
    tick(1);
    check_reg("resume_load", 2'd2, 32'd6);
    tick(1);
    check_reg("resume_reload", 2'd2, 32'd10);
    // PRESET change mid-count does not disturb the running countdown
    wr(2'd1, 32'd4);
    check_reg("midpre_count", 2'd2, 32'd9);
    tick(8);
    check_irq("midpre_pre_int", 1'b0);
    tick(1);
    check_irq("midpre_int", 1'b1);
    // CTRL write on the INT edge keeps EN set
    wr(2'd0, 32'h9);
    check_reg("int_wr_prio", 2'd0, 32'h9);
    check_irq("int_wr_clr", 1'b0);
    tick(2);
    check_reg("new_preset_used", 2'd2, 32'd4);
    wr(2'd0, 32'h0);
    tick(4);

    // Reset mid-count aborts everything
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(5);
    check_reg("pre_rst_count", 2'd2, 32'd2);
    reset = 1'b0;
    #1;
    check_irq("arst_irq", 1'b0);
    check_reg("arst_ctrl", 2'd0, 32'h0);
    check_reg("arst_preset", 2'd1, 32'h0);
    check_reg("arst_count", 2'd2, 32'h0);
    tick(2);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check_irq("post_rst_irq", 1'b0);
    end
    check_reg("post_rst_count", 2'd2, 32'h0);

    // PRESET=0: INT at edge 3, then COUNT write
    wr(2'd0, 32'h9);
    tick(2);
    check_irq("p0_irq_e2", 1'b0);
    tick(1);
    check_irq("p0_irq_e3", 1'b1);
    wr(2'd2, 32'h7);
`ifdef TC_COUNT_WR_EN
    check_reg("count_wr", 2'd2, 32'h7);
`else
    check_reg("count_wr", 2'd2, 32'h0);
`endif
    tick(2);
`ifdef TC_COUNT_WR_EN
    check_reg("count_wr_hold", 2'd2, 32'h7);
`else
    check_reg("count_wr_hold", 2'd2, 32'h0);
`endif
    check_irq("count_wr_irq", 1'b1);

    // MODE=10 behaves as one-shot
    wr(2'd0, 32'hD);
    tick(3);
    check_irq("m10_irq", 1'b1);
    tick(1);
    check_reg("m10_ctrl", 2'd0, 32'hC);

    // Reserved register and CTRL upper bits
    wr(2'd3, 32'hFFFF_FFFF);
    check_reg("rsvd_read", 2'd3, 32'h0);
    check_reg("rsvd_no_alias", 2'd0, 32'hC);
    wr(2'd0, 32'hFFFF_FFF6);
    check_reg("ctrl_upper", 2'd0, 32'h6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32: implemented width of PRESET/COUNT; upper bits read as 0, writes to them are ignored.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Addr, input, 32, register address; only Addr[3:2] is decoded (address decode is done by the bridge).
REQ-005 SHALL have port WE, input, 1, word write strobe, sampled on the clk edge.
REQ-006 SHALL have port Din, input, 32, write data.
REQ-007 SHALL have port Dout, output, 32, combinational read data.
REQ-008 SHALL have port IRQ, output, 1, interrupt request, level.

Function
REQ-009 SHALL decode the register map as Addr[3:2]: 0=CTRL, 1=PRESET, 2=COUNT (read-only unless REQ-024 applies), 3=reserved (reads 0, writes ignored).
REQ-010 SHALL define CTRL[0]=EN, CTRL[2:1]=MODE (00 one-shot, 01 auto-reload, 1x treated as 00), CTRL[3]=IM; CTRL[31:4] read 0.
REQ-011 SHALL drive Dout combinationally from the current register value selected by Addr[3:2], zero-extended.
REQ-012 SHALL implement the 4-state FSM IDLE, LOAD, CNT, INT.
REQ-013 IDLE: EN=1 -> LOAD next edge; else stay; COUNT holds.
REQ-014 LOAD: COUNT<=PRESET; -> CNT.
REQ-015 CNT: EN=0 -> IDLE with COUNT held; else COUNT<=1 or 0 -> COUNT<=0, flag<=1, -> INT; else COUNT<=COUNT-1.
REQ-016 INT: MODE 00 -> EN<=0, flag held; MODE 01 -> flag<=0; both -> IDLE.
REQ-017 SHALL drive IRQ = IM & flag; MODE 01 therefore gives an exactly one-cycle pulse with period PRESET+3 cycles (PRESET>=1).
REQ-018 SHALL clear flag on any CPU write to CTRL or PRESET.
REQ-019 SHALL produce latency: write of CTRL with EN=1 at edge 0 -> LOAD at edge 1, COUNT=PRESET at edge 2, INT/flag at edge 2+max(PRESET,1).
REQ-020 SHALL give a CPU write to CTRL priority over the INT-state EN clear on the same edge.
REQ-021 SHALL apply a PRESET write mid-count only at the next LOAD; the current countdown is unaffected.
REQ-022 SHALL resume a count paused by EN=0 via IDLE->LOAD, i.e. restart from PRESET, not from the held COUNT.

Reset
REQ-023 SHALL, while reset=0, asynchronously force CTRL=0, PRESET=0, COUNT=0, flag=0, state=IDLE, IRQ=0; reset asserted mid-count SHALL abort with no IRQ after release.

Configuration
REQ-024 SHALL, with macro TC_COUNT_WR_EN defined, accept CPU writes to COUNT (new value overrides any FSM update on that edge; in CNT, counting continues from it); without it, COUNT writes SHALL be ignored.

Verification
REQ-025 SHALL cover: PRESET=3, CTRL=0x9 at edge 0 -> COUNT 3,2,1,0 at edges 2-5, IRQ=1 from edge 5 and held, CTRL reads 0x8 after edge 6.
REQ-026 SHALL cover: PRESET=2, CTRL=0xB -> IRQ one-cycle pulses every 5 cycles, CTRL stays 0xB.
REQ-027 SHALL cover: mode 0 IRQ high, write PRESET=5 -> IRQ=0 next cycle; write CTRL=0x1 with IM=0 -> count runs, IRQ stays 0.
REQ-028 SHALL cover: PRESET=10, start, write CTRL=0x8 at COUNT=6 -> COUNT holds 6; re-enable -> COUNT reloads 10.
REQ-029 SHALL cover: reset=0 asserted at COUNT=2 -> all registers 0, IRQ 0 immediately and after release.
REQ-030 SHALL cover: PRESET=0 start -> INT at edge 3, IRQ high; COUNT write 0x7 -> reads 7 with TC_COUNT_WR_EN, unchanged without.
